uart_tx: RTL and testbench
==========================

# uart_tx

Asynchronous serial (UART) transmitter: accepts one parallel word per valid/ready handshake and shifts it out LSB-first on a single line as start bit, data bits, optional parity bit and stop bit(s). It is the transmit end of the team's UART link and pairs with the UART receiver at the far end of the line. It sits between an on-chip producer (register file, FIFO, test sequencer) and the chip-level TX pad.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal range 5–9.
- CLKS_PER_BIT, 16: clk cycles per bit period; must be ≥ 2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  transmitter can accept a word. High only in IDLE.
- tx_data  input  DATA_WIDTH  word to send; sampled only on an accept.
- txd  output  1  serial line. Idle level is high. Driven from a flop, so it is glitch-free.
- busy  output  1  a frame is in progress (any state other than IDLE).

## Operation
- States:
  - IDLE → START on accept.
  - START → DATA.
  - DATA → PARITY when PARITY_EN = 1, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE after STOP_BITS bit periods.
- Accept: tx_valid && tx_ready at a rising edge. On that edge:
  - tx_data is latched into the shift register;
  - the parity bit is computed from the latched word;
  - the state moves to START.
- Handshake rules:
  - A word offered while tx_ready = 0 is not lost. The producer holds tx_valid/tx_data stable until accept.
  - tx_data and tx_valid are don't-care after accept. Changes mid-frame must not affect the frame.
- txd per state:
  - IDLE: 1.
  - START: 0.
  - DATA: data bit, LSB first.
  - PARITY: parity bit.
  - STOP: 1.
- Parity bit: even parity = XOR of all DATA_WIDTH data bits; odd parity = the inverse of that.
- Counters:
  - Baud counter, width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 inside each bit period and wraps to 0 at each bit boundary.
  - Bit counter, width $clog2(DATA_WIDTH) (minimum 1). It indexes data bits and counts stop bits.
  - Both counters are cleared on entry to START.
- No accept is possible while busy = 1. tx_ready is a pure decode of state == IDLE.

## Timing
- Reset values (asserted immediately, asynchronously):
  - txd = 1, tx_ready = 1, busy = 0;
  - state = IDLE, all counters = 0, shift register = 0.
- Latency: an accept at edge N makes txd fall and busy rise after edge N (first START cycle = N+1).
- Every bit period, including start, parity and stop, lasts exactly CLKS_PER_BIT cycles.
- Frame length: F = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles, i.e. cycles N+1..N+F.
- Cycle N+F+1 is IDLE, with tx_ready = 1 and busy = 0.
- Back-to-back frames: with tx_valid held high, the next accept occurs at edge N+F+1 and the next START begins at N+F+2. Minimum inter-frame idle is one clk.
- Reset mid-frame: txd returns to 1 immediately and the frame is abandoned, no partial stop bit. After release, the block starts in IDLE and accepts normally.
- Reset released while tx_valid = 1: accept occurs at the first rising edge after release.

## Test plan
- Reset: hold rst_n = 0 → txd = 1, tx_ready = 1, busy = 0.
- Drive rst_n low asynchronously mid-cycle → outputs take reset values without waiting for a clk edge.
- Basic frame (DATA_WIDTH = 8, CLKS_PER_BIT = 4, no parity, 1 stop), send 0xA5 accepted at edge 0. Required:
  - txd = 0 on cycles 1–4;
  - bits 1,0,1,0,0,1,0,1, each held 4 cycles, on cycles 5–36;
  - txd = 1 on cycles 37–40;
  - tx_ready = 1 on cycle 41;
  - busy = 1 exactly on cycles 1–40.
- Parity: PARITY_EN = 1, 0x07.
  - Even parity → parity bit 1, on cycles 37–40.
  - Odd parity → parity bit 0.
  - 0x00 with even parity → 0.
  - In all cases the stop bit follows on cycles 41–44.
- Back-to-back and 2 stop bits: tx_valid held high with 0x55 then 0xAA, STOP_BITS = 2.
  - Second accept at edge 45, second START on cycles 46–49.
  - txd high on cycles 37–45.
  - No word dropped or duplicated.
- Mid-frame input changes: change tx_data to 0xFF and pulse tx_valid during the DATA state.
  - The serial bits still match the originally accepted word.
  - No second accept until tx_ready returns high.
- Reset mid-frame: rst_n low during data bit 3.
  - txd = 1 and busy = 0 immediately.
  - After release, sending 0x3C produces a clean, correct frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: takes one word per valid/ready handshake and sends it LSB-first
// as start bit, data bits, optional parity bit and one or two stop bits.
module uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  txd,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             ODD_SEL   = (PARITY_ODD != 0);
  localparam logic             PAR_ON    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                  state_q, state_n;
  logic [CNT_W-1:0]        baud_q, baud_n;
  logic [BIT_W-1:0]        bit_q, bit_n;
  logic [DATA_WIDTH-1:0]   shift_q, shift_n;
  logic                    parity_q, parity_n;
  logic                    txd_q, txd_n;
  logic                    busy_q, busy_n;
  logic                    bit_end;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign tx_ready = (state_q == ST_IDLE);
  assign txd      = txd_q;
  assign busy     = busy_q;

  // State, counters, shift register and the registered line/busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      baud_q   <= baud_n;
      bit_q    <= bit_n;
      shift_q  <= shift_n;
      parity_q <= parity_n;
      txd_q    <= txd_n;
      busy_q   <= busy_n;
    end
  end

  // Next-state logic; txd/busy are derived from the next state so they line up with it
  always_comb begin
    state_n  = state_q;
    baud_n   = baud_q;
    bit_n    = bit_q;
    shift_n  = shift_q;
    parity_n = parity_q;
    txd_n    = 1'b1;
    busy_n   = 1'b0;

    if (state_q != ST_IDLE) begin
      baud_n = bit_end ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_n  = ST_START;
          shift_n  = tx_data;
          parity_n = (^tx_data) ^ ODD_SEL;
          baud_n   = '0;
          bit_n    = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_n = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_n   = '0;
            state_n = PAR_ON ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_n   = '0;
            state_n = ST_IDLE;
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    case (state_n)
      ST_START:  txd_n = 1'b0;
      ST_DATA:   txd_n = shift_n[0];
      ST_PARITY: txd_n = parity_n;
      default:   txd_n = 1'b1;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations share one stimulus stream; each is compared
// every cycle against a queue of expected line levels built from the frame format.
module tb_uart_tx;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;

  logic txd0, rdy0, busy0;
  logic txd1, rdy1, busy1;
  logic txd2, rdy2, busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 8 data, 4 clk/bit, no parity, 1 stop
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(rdy0),
    .tx_data(tx_data), .txd(txd0), .busy(busy0)
  );

  // 8 data, 4 clk/bit, even parity, 2 stop
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(rdy1),
    .tx_data(tx_data), .txd(txd1), .busy(busy1)
  );

  // 5 data, 3 clk/bit, odd parity, 1 stop
  uart_tx #(.DATA_WIDTH(5), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(rdy2),
    .tx_data(tx_data[4:0]), .txd(txd2), .busy(busy2)
  );

  typedef bit bitq_t[$];

  // Expected line level for every clk of one frame
  function automatic bitq_t build_frame(input logic [7:0] d, input int dw, input int cpb,
                                        input int pen, input int podd, input int sb);
    bitq_t q;
    bit    p;
    p = (podd != 0);
    for (int i = 0; i < dw; i++) p ^= d[i];
    for (int k = 0; k < cpb; k++) q.push_back(1'b0);
    for (int i = 0; i < dw; i++)
      for (int k = 0; k < cpb; k++) q.push_back(d[i]);
    if (pen != 0)
      for (int k = 0; k < cpb; k++) q.push_back(p);
    for (int k = 0; k < sb * cpb; k++) q.push_back(1'b1);
    return q;
  endfunction

  bitq_t q0, q1, q2;

  // Reference: a unit is idle when its queue is empty, and only then accepts a word
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (q0.size() != 0) void'(q0.pop_front());
      else if (tx_valid) q0 = build_frame(tx_data, 8, 4, 0, 0, 1);
      if (q1.size() != 0) void'(q1.pop_front());
      else if (tx_valid) q1 = build_frame(tx_data, 8, 4, 1, 0, 2);
      if (q2.size() != 0) void'(q2.pop_front());
      else if (tx_valid) q2 = build_frame(tx_data, 5, 3, 1, 1, 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_unit(input string name, input logic t, input logic r, input logic b,
                            input bitq_t q);
    logic exp_txd;
    exp_txd = (q.size() != 0) ? q[0] : 1'b1;
    check({name, ".txd"}, 32'(t), 32'(exp_txd));
    check({name, ".tx_ready"}, 32'(r), 32'(q.size() == 0));
    check({name, ".busy"}, 32'(b), 32'(q.size() != 0));
  endtask

  task automatic check_reset(input string when);
    check({when, ".u0.txd"}, 32'(txd0), 32'd1);
    check({when, ".u0.tx_ready"}, 32'(rdy0), 32'd1);
    check({when, ".u0.busy"}, 32'(busy0), 32'd0);
    check({when, ".u1.txd"}, 32'(txd1), 32'd1);
    check({when, ".u1.busy"}, 32'(busy1), 32'd0);
    check({when, ".u2.txd"}, 32'(txd2), 32'd1);
    check({when, ".u2.busy"}, 32'(busy2), 32'd0);
  endtask

  always @(negedge clk) begin
    check_unit("u0", txd0, rdy0, busy0, q0);
    check_unit("u1", txd1, rdy1, busy1, q1);
    check_unit("u2", txd2, rdy2, busy2, q2);
  end

  task automatic send(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic and parity frames
    send(8'hA5);
    repeat (60) @(negedge clk);
    send(8'h07);
    repeat (60) @(negedge clk);
    send(8'h00);
    repeat (60) @(negedge clk);

    // Back-to-back with valid held high
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    repeat (20) @(negedge clk);
    tx_data = 8'hAA;
    repeat (150) @(negedge clk);
    tx_valid = 1'b0;
    repeat (60) @(negedge clk);

    // Input changes while frames are in progress
    send(8'hC3);
    repeat (8) @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (60) @(negedge clk);

    // Asynchronous reset during data bit 3 of u0, then a clean frame
    send(8'h96);
    repeat (17) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async");
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (60) @(negedge clk);

    // Random traffic with data changing every cycle
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
    end
    tx_valid = 1'b0;
    repeat (60) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
